// File: rtl/dds_sweep_controller_pkg.sv
// Shared types and codes for the DDS sweep controller.
package dds_sweep_controller_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  localparam logic [1:0] SHAPE_SINE     = 2'b00;
  localparam logic [1:0] SHAPE_TRIANGLE = 2'b01;
  localparam logic [1:0] SHAPE_SQUARE   = 2'b10;

  // Any request outside sine/triangle is applied as square.
  function automatic logic [1:0] norm_shape(input logic [1:0] req);
    case (req)
      SHAPE_SINE:     norm_shape = SHAPE_SINE;
      SHAPE_TRIANGLE: norm_shape = SHAPE_TRIANGLE;
      default:        norm_shape = SHAPE_SQUARE;
    endcase
  endfunction

endpackage

// File: rtl/dds_defines.sv
// Global defines shared by the DDS datapath blocks.
`ifndef DDS_DEFINES_SV
`define DDS_DEFINES_SV
`define ROM_PHASE_BIT 10
`endif

// File: rtl/dds_phase_accumulator.sv
// Phase accumulator: clear has priority over enable; wrap_c is the carry of the pending add.
`ifndef ROM_PHASE_BIT
`include "dds_defines.sv"
`endif

module dds_phase_accumulator #(
  parameter int unsigned ACC_BITS   = 32,
  parameter int unsigned PHASE_BITS = `ROM_PHASE_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [ACC_BITS-1:0]   tuning_word,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  wrap_c
);

  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS:0]   sum;

  assign sum    = {1'b0, acc} + {1'b0, tuning_word};
  assign wrap_c = enable && !clear && sum[ACC_BITS];
  assign phase  = acc[ACC_BITS-1 -: PHASE_BITS];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= sum[ACC_BITS-1:0];
    end
  end

endmodule

// File: rtl/dds_sweep_controller.sv
// Linear upward frequency sweep sequencer driving the DDS phase accumulator.
`ifndef ROM_PHASE_BIT
`include "dds_defines.sv"
`endif

module dds_sweep_controller
  import dds_sweep_controller_pkg::*;
#(
  parameter int unsigned ACC_BITS   = 32,
  parameter int unsigned PHASE_BITS = `ROM_PHASE_BIT,
  parameter int unsigned DWELL_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ACC_BITS-1:0]   f_start,
  input  logic [ACC_BITS-1:0]   f_stop,
  input  logic [ACC_BITS-1:0]   f_step,
  input  logic [DWELL_BITS-1:0] dwell,
  input  logic                  mode,
  input  logic [1:0]            shape_req,
  output logic [PHASE_BITS-1:0] phase,
  output logic [1:0]            shape,
  output logic [ACC_BITS-1:0]   tuning_word,
  output logic                  busy,
  output logic                  done
);

  state_e                state, state_n;
  logic [ACC_BITS-1:0]   tuning_word_n, f_start_l, f_start_n, f_stop_l, f_stop_n;
  logic [ACC_BITS-1:0]   f_step_l, f_step_n;
  logic [DWELL_BITS-1:0] dwell_l, dwell_n, dwell_cnt, dwell_cnt_n;
  logic                  mode_l, mode_n, done_n;
  logic [1:0]            shape_n;
  logic [ACC_BITS:0]     step_sum;
  logic                  acc_clear, acc_enable, wrap_c;

  dds_phase_accumulator #(
    .ACC_BITS   (ACC_BITS),
    .PHASE_BITS (PHASE_BITS)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear),
    .enable      (acc_enable),
    .tuning_word (tuning_word),
    .phase       (phase),
    .wrap_c      (wrap_c)
  );

  assign busy = (state == ST_SWEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tuning_word <= '0;
      shape       <= SHAPE_SINE;
      done        <= 1'b0;
      dwell_cnt   <= '0;
      f_start_l   <= '0;
      f_stop_l    <= '0;
      f_step_l    <= '0;
      dwell_l     <= '0;
      mode_l      <= 1'b0;
    end else begin
      state       <= state_n;
      tuning_word <= tuning_word_n;
      shape       <= shape_n;
      done        <= done_n;
      dwell_cnt   <= dwell_cnt_n;
      f_start_l   <= f_start_n;
      f_stop_l    <= f_stop_n;
      f_step_l    <= f_step_n;
      dwell_l     <= dwell_n;
      mode_l      <= mode_n;
    end
  end

  // Next-state: stop outranks dwell end; step sum is one bit wider so the clamp never sees overflow.
  always_comb begin
    state_n       = state;
    tuning_word_n = tuning_word;
    shape_n       = shape;
    done_n        = 1'b0;
    dwell_cnt_n   = dwell_cnt;
    f_start_n     = f_start_l;
    f_stop_n      = f_stop_l;
    f_step_n      = f_step_l;
    dwell_n       = dwell_l;
    mode_n        = mode_l;
    acc_clear     = 1'b0;
    acc_enable    = 1'b0;
    step_sum      = {1'b0, tuning_word} + {1'b0, f_step_l};

    case (state)
      ST_IDLE: begin
        acc_clear     = 1'b1;
        tuning_word_n = '0;
        dwell_cnt_n   = '0;
        shape_n       = norm_shape(shape_req);
        if (start) begin
          f_start_n     = f_start;
          f_stop_n      = f_stop;
          f_step_n      = f_step;
          dwell_n       = (dwell == '0) ? DWELL_BITS'(1) : dwell;
          mode_n        = mode;
          tuning_word_n = f_start;
          state_n       = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        acc_enable = 1'b1;
        if (stop) begin
          acc_clear     = 1'b1;
          tuning_word_n = '0;
          dwell_cnt_n   = '0;
          state_n       = ST_IDLE;
        end else begin
          dwell_cnt_n = dwell_cnt + DWELL_BITS'(1);
          if (wrap_c) begin
            shape_n = norm_shape(shape_req);
          end
          if (dwell_cnt == dwell_l - DWELL_BITS'(1)) begin
            dwell_cnt_n = '0;
            if (tuning_word == f_stop_l) begin
              done_n = 1'b1;
              if (mode_l) begin
                tuning_word_n = f_start_l;
              end else begin
                acc_clear     = 1'b1;
                tuning_word_n = '0;
                state_n       = ST_IDLE;
              end
            end else if (step_sum > {1'b0, f_stop_l}) begin
              tuning_word_n = f_stop_l;
            end else begin
              tuning_word_n = step_sum[ACC_BITS-1:0];
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed self-checking bench for dds_sweep_controller.
module tb_dds_sweep_controller;

  logic        clk = 1'b0;
  logic        rst, start, stop, mode;
  logic [31:0] f_start, f_stop, f_step, tuning_word;
  logic [15:0] dwell;
  logic [1:0]  shape_req, shape;
  logic [9:0]  phase;
  logic        busy, done;

  int tests  = 0;
  int errors = 0;

  dds_sweep_controller #(
    .ACC_BITS   (32),
    .PHASE_BITS (10),
    .DWELL_BITS (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .f_start     (f_start),
    .f_stop      (f_stop),
    .f_step      (f_step),
    .dwell       (dwell),
    .mode        (mode),
    .shape_req   (shape_req),
    .phase       (phase),
    .shape       (shape),
    .tuning_word (tuning_word),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] exp_tw,
                            input logic exp_busy, input logic exp_done);
    check({tag, ".tw"},   64'(tuning_word), 64'(exp_tw));
    check({tag, ".busy"}, 64'(busy),        64'(exp_busy));
    check({tag, ".done"}, 64'(done),        64'(exp_done));
  endtask

  // Pulse start with the given settings, then scramble the settings inputs.
  task automatic do_start(input logic [31:0] fs, input logic [31:0] fe,
                          input logic [31:0] fp, input logic [15:0] dw, input logic md);
    f_start = fs; f_stop = fe; f_step = fp; dwell = dw; mode = md;
    start = 1'b1;
    tick();
    start   = 1'b0;
    f_start = 32'hDEAD_BEEF;
    f_stop  = 32'h0000_0001;
    f_step  = 32'hFFFF_FFFF;
    dwell   = 16'd7;
    mode    = ~md;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    shape_req = 2'b11;
    tick(); tick();
    check_outs("reset", 32'h0, 1'b0, 1'b0);
    check("reset.phase", 64'(phase), 64'(0));
    check("reset.shape", 64'(shape), 64'(0));

    rst = 1'b0;
    tick();
    check("idle.shape_sq", 64'(shape), 64'(2));
    shape_req = 2'b01;
    tick();
    check("idle.shape_tri", 64'(shape), 64'(1));
    shape_req = 2'b00;
    tick();

    // Four-step single sweep, dwell 4
    do_start(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd4, 1'b0);
    check("s1.phase0", 64'(phase), 64'(0));
    for (int t = 1; t <= 16; t++) begin
      check_outs($sformatf("s1.t%0d", t), 32'((((t - 1) / 4) + 1) << 24), 1'b1, 1'b0);
      if (t == 2) check("s1.phase_t2", 64'(phase), 64'(4));
      if (t == 3) check("s1.phase_t3", 64'(phase), 64'(8));
      tick();
    end
    check_outs("s1.end", 32'h0, 1'b0, 1'b1);
    check("s1.end_phase", 64'(phase), 64'(0));
    tick();
    check("s1.done_clr", 64'(done), 64'(0));

    // Clamped last step; dwell 0 behaves as dwell 1
    for (int k = 0; k < 2; k++) begin
      do_start(32'd100, 32'd250, 32'd100, (k == 0) ? 16'd1 : 16'd0, 1'b0);
      check_outs($sformatf("clamp%0d.a", k), 32'd100, 1'b1, 1'b0);
      tick();
      check_outs($sformatf("clamp%0d.b", k), 32'd200, 1'b1, 1'b0);
      tick();
      check_outs($sformatf("clamp%0d.c", k), 32'd250, 1'b1, 1'b0);
      tick();
      check_outs($sformatf("clamp%0d.end", k), 32'd0, 1'b0, 1'b1);
      tick();
    end

    // f_stop below f_start: clamp to f_stop after first dwell
    do_start(32'd500, 32'd300, 32'd10, 16'd2, 1'b0);
    check_outs("rev.t1", 32'd500, 1'b1, 1'b0);
    tick();
    check_outs("rev.t2", 32'd500, 1'b1, 1'b0);
    tick();
    check_outs("rev.t3", 32'd300, 1'b1, 1'b0);
    tick();
    check_outs("rev.t4", 32'd300, 1'b1, 1'b0);
    tick();
    check_outs("rev.end", 32'd0, 1'b0, 1'b1);
    tick();

    // Continuous mode: phase keeps running across the restart
    do_start(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd4, 1'b1);
    for (int t = 1; t <= 16; t++) tick();
    check_outs("cont.p1", 32'h0100_0000, 1'b1, 1'b1);
    check("cont.p1_phase", 64'(phase), 64'(160));
    tick();
    check_outs("cont.t18", 32'h0100_0000, 1'b1, 1'b0);
    for (int t = 18; t < 33; t++) tick();
    check_outs("cont.p2", 32'h0100_0000, 1'b1, 1'b1);
    check("cont.p2_phase", 64'(phase), 64'(320));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_outs("cont.stop", 32'h0, 1'b0, 1'b0);
    check("cont.stop_phase", 64'(phase), 64'(0));
    tick();
    check("cont.no_done", 64'(done), 64'(0));

    // Stop coincident with the final dwell end suppresses done
    do_start(32'd100, 32'd250, 32'd100, 16'd1, 1'b0);
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_outs("stopend", 32'h0, 1'b0, 1'b0);
    tick();
    check("stopend.no_done", 64'(done), 64'(0));

    // Shape change held until the phase wraps
    shape_req = 2'b00;
    tick();
    do_start(32'h4000_0000, 32'h4000_0000, 32'h0, 16'd1000, 1'b0);
    check("shp.t1", 64'(shape), 64'(0));
    tick();
    check("shp.t2_phase", 64'(phase), 64'(256));
    shape_req = 2'b01;
    tick();
    check("shp.t3", 64'(shape), 64'(0));
    tick();
    check("shp.t4", 64'(shape), 64'(0));
    check("shp.t4_phase", 64'(phase), 64'(768));
    tick();
    check("shp.t5", 64'(shape), 64'(1));
    check("shp.t5_phase", 64'(phase), 64'(0));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("shp.stop", 64'(busy), 64'(0));
    shape_req = 2'b00;
    tick();

    // Start while busy is ignored
    do_start(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd4, 1'b0);
    for (int t = 1; t <= 16; t++) begin
      check_outs($sformatf("ign.t%0d", t), 32'((((t - 1) / 4) + 1) << 24), 1'b1, 1'b0);
      if (t == 5) begin
        f_start = 32'd7; f_stop = 32'd9; f_step = 32'd1; dwell = 16'd1; mode = 1'b1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check_outs("ign.end", 32'h0, 1'b0, 1'b1);
    tick();

    // Reset mid-sweep, then a fresh start
    shape_req = 2'b10;
    do_start(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd4, 1'b0);
    for (int t = 0; t < 5; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outs("rstmid", 32'h0, 1'b0, 1'b0);
    check("rstmid.phase", 64'(phase), 64'(0));
    check("rstmid.shape", 64'(shape), 64'(0));
    do_start(32'd100, 32'd250, 32'd100, 16'd1, 1'b0);
    check_outs("rstmid.a", 32'd100, 1'b1, 1'b0);
    tick();
    check_outs("rstmid.b", 32'd200, 1'b1, 1'b0);
    tick();
    check_outs("rstmid.c", 32'd250, 1'b1, 1'b0);
    tick();
    check_outs("rstmid.end", 32'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
